// File: rtl/canvas_i2c_reader_pkg.sv
// Shared types and constants for the canvas I2C cursor reader.
package canvas_i2c_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_READ,
        ST_MACK,
        ST_STOP
    } state_t;

    localparam logic [6:0] CANVAS_ADDR = 7'h64;

    localparam logic [1:0] BYTE_X      = 2'd0;
    localparam logic [1:0] BYTE_Y      = 2'd1;
    localparam logic [1:0] BYTE_STATUS = 2'd2;

endpackage

// File: rtl/canvas_i2c_reader_quarter_timer.sv
// Bit-slot timer: four quarters of CLK_DIV cycles each, with the SCL-high
// quarter frozen while a slave stretches the clock.
module i2c_quarter_timer #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_scl_in,
    output logic [1:0] o_quarter,
    output logic       o_sample,
    output logic       o_slot_end
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic [1:0] r_quarter;
    logic       w_tc;
    logic       w_hold;

    assign w_tc   = (r_cnt == 8'd0);
    assign w_hold = (r_quarter == 2'd2) && !i_scl_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= RELOAD;
            r_quarter <= 2'd0;
        end else if (!i_run) begin
            r_cnt     <= RELOAD;
            r_quarter <= 2'd0;
        end else if (!w_hold) begin
            if (w_tc) begin
                r_cnt     <= RELOAD;
                r_quarter <= r_quarter + 2'd1;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_quarter  = r_quarter;
    assign o_sample   = i_run && w_tc && (r_quarter == 2'd2) && i_scl_in;
    assign o_slot_end = i_run && w_tc && (r_quarter == 2'd3);

endmodule

// File: rtl/canvas_i2c_reader.sv
// I2C master that reads the cursor X, Y and status bytes from the canvas
// slave in one START / address / 3-byte read / STOP transaction.
module canvas_i2c_reader
    import canvas_i2c_reader_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = CANVAS_ADDR,
    parameter int         CLK_DIV  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_error,
    output logic [7:0] o_x_out,
    output logic [7:0] o_y_out,
    output logic [7:0] o_status_out,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_scl_oe,
    output logic       o_sda_oe
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_quarter;
    logic       w_sample;
    logic       w_slot_end;
    logic       w_accept;
    logic [7:0] w_addr_byte;

    logic [2:0] r_bit_cnt;
    logic [1:0] r_byte_idx;
    logic [7:0] r_shift;
    logic [7:0] r_byte_x;
    logic [7:0] r_byte_y;
    logic [7:0] r_byte_st;
    logic       r_done;
    logic       r_ack_error;
    logic [7:0] r_x_out;
    logic [7:0] r_y_out;
    logic [7:0] r_status_out;

    assign w_addr_byte = {I2C_ADDR, 1'b1};
    assign w_accept    = (r_state == ST_IDLE) && i_start;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (r_state != ST_IDLE),
        .i_scl_in   (i_scl_in),
        .o_quarter  (w_quarter),
        .o_sample   (w_sample),
        .o_slot_end (w_slot_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_scl_oe     = 1'b0;
        o_sda_oe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = ST_START;
            end
            ST_START: begin
                // SDA falls in Q2 with SCL high, SCL follows in Q3
                o_scl_oe = (w_quarter == 2'd3);
                o_sda_oe = w_quarter[1];
                if (w_slot_end) w_next_state = ST_ADDR;
            end
            ST_ADDR: begin
                o_scl_oe = !w_quarter[1];
                o_sda_oe = !w_addr_byte[r_bit_cnt];
                if (w_slot_end && (r_bit_cnt == 3'd0)) w_next_state = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                o_scl_oe = !w_quarter[1];
                if (w_slot_end) w_next_state = r_ack_error ? ST_STOP : ST_READ;
            end
            ST_READ: begin
                o_scl_oe = !w_quarter[1];
                if (w_slot_end && (r_bit_cnt == 3'd0)) w_next_state = ST_MACK;
            end
            ST_MACK: begin
                o_scl_oe = !w_quarter[1];
                o_sda_oe = (r_byte_idx != BYTE_STATUS);
                if (w_slot_end)
                    w_next_state = (r_byte_idx == BYTE_STATUS) ? ST_STOP : ST_READ;
            end
            ST_STOP: begin
                o_scl_oe = !w_quarter[1];
                o_sda_oe = (w_quarter != 2'd3);
                if (w_slot_end) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The 3-bit bit counter wraps 0 -> 7, so it is already primed for the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 3'd7;
            r_byte_idx   <= BYTE_X;
            r_shift      <= 8'h00;
            r_byte_x     <= 8'h00;
            r_byte_y     <= 8'h00;
            r_byte_st    <= 8'h00;
            r_done       <= 1'b0;
            r_ack_error  <= 1'b0;
            r_x_out      <= 8'h00;
            r_y_out      <= 8'h00;
            r_status_out <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ack_error <= 1'b0;
                r_bit_cnt   <= 3'd7;
                r_byte_idx  <= BYTE_X;
            end
            if (w_sample && (r_state == ST_ADDR_ACK)) r_ack_error <= i_sda_in;
            if (w_sample && (r_state == ST_READ)) r_shift <= {r_shift[6:0], i_sda_in};
            if (w_slot_end && ((r_state == ST_ADDR) || (r_state == ST_READ)))
                r_bit_cnt <= r_bit_cnt - 3'd1;
            if (w_slot_end && (r_state == ST_READ) && (r_bit_cnt == 3'd0)) begin
                case (r_byte_idx)
                    BYTE_X:  r_byte_x  <= r_shift;
                    BYTE_Y:  r_byte_y  <= r_shift;
                    default: r_byte_st <= r_shift;
                endcase
            end
            if (w_slot_end && (r_state == ST_MACK)) r_byte_idx <= r_byte_idx + 2'd1;
            if (w_slot_end && (r_state == ST_STOP)) begin
                r_done <= 1'b1;
                if (!r_ack_error) begin
                    r_x_out      <= r_byte_x;
                    r_y_out      <= r_byte_y;
                    r_status_out <= r_byte_st;
                end
            end
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_ack_error  = r_ack_error;
    assign o_x_out      = r_x_out;
    assign o_y_out      = r_y_out;
    assign o_status_out = r_status_out;

endmodule
